apple_spawner: RTL and testbench

//  Places the apple on the 16x16 LED grid and picks a new free cell each time the snake eats it.
//  A free-running LFSR proposes candidate cells. Each candidate is checked with the snake body

---
 rtl/snake_pkg.sv | 28 ++
 rtl/lfsr16.sv | 23 ++
 rtl/apple_spawner.sv | 190 +++++++++++++++++++
 tb/tb_apple_spawner.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks: grid geometry,
// the apple spawner state encoding and the LFSR feedback polynomial.
package snake_pkg;

  localparam int GRID_DIM = 16;
  localparam int COORD_W  = $clog2(GRID_DIM);

  // One grid coordinate (row or column).
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    QUERY,
    COMMIT,
    SCAN,
    FULL
  } spawn_state_t;

  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Shared by any block that needs cheap pseudo-random numbers.
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1  // must be nonzero or the LFSR locks up
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Advance one step every clock, regardless of what the consumer is doing.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: keeps the apple position for the 16x16 LED grid and, when the
// snake eats it, searches for a free cell by querying the body tracker over a
// req/ack occupancy handshake with LFSR-proposed candidates.
// Optional feature macro: APPLE_SCAN_FALLBACK_EN -- after MAX_TRIES occupied
// random candidates, fall back to a raster scan and flag board_full when no
// free cell exists.
module apple_spawner
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter coord_t      INIT_I    = 4'd10,
  parameter coord_t      INIT_J    = 4'd14,
  parameter int          MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gameOver,
  input  logic       eaten,
  output logic       occ_req,
  output logic [3:0] occ_i,
  output logic [3:0] occ_j,
  input  logic       occ_ack,
  input  logic       occ_busy,
  output logic [3:0] i_apple,
  output logic [3:0] j_apple,
  output logic       apple_valid,
  output logic       spawn_done,
  output logic       board_full
);

  localparam int               TRY_W   = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

  spawn_state_t     state;
  logic [15:0]      lfsr_q;
  logic [TRY_W-1:0] try_cnt;
  logic             locked;   // a spawn was aborted by gameOver; no more spawns until reset
  logic             abort;

`ifdef APPLE_SCAN_FALLBACK_EN
  logic [7:0]       scan_idx; // {row, column} of the next raster-scan cell
`endif

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only the low byte forms a candidate cell; the upper bits are left for reuse elsewhere.
  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_q[15:8];

  // gameOver cancels any spawn in flight; FULL is terminal and ignores it.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    abort = 1'b0;
    if (gameOver && (state != IDLE) && (state != FULL)) begin
      abort = 1'b1;
    end
  end

`ifndef APPLE_SCAN_FALLBACK_EN
  assign board_full = 1'b0;
`endif

  // Spawn FSM with registered handshake and apple outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      occ_req     <= 1'b0;
      occ_i       <= '0;
      occ_j       <= '0;
      i_apple     <= INIT_I;
      j_apple     <= INIT_J;
      apple_valid <= 1'b1;
      spawn_done  <= 1'b0;
      try_cnt     <= '0;
      locked      <= 1'b0;
`ifdef APPLE_SCAN_FALLBACK_EN
      scan_idx    <= '0;
      board_full  <= 1'b0;
`endif
    end else begin
      spawn_done <= 1'b0;

      case (state)
        IDLE: begin
          if (eaten && !gameOver && !locked) begin
            apple_valid <= 1'b0;
            state       <= GEN;
          end
        end

        GEN: begin
`ifdef APPLE_SCAN_FALLBACK_EN
          if (try_cnt == TRY_MAX) begin
            scan_idx <= '0;
            state    <= SCAN;
          end else begin
`else
          begin
`endif
            occ_i   <= lfsr_q[3:0];
            occ_j   <= lfsr_q[7:4];
            occ_req <= 1'b1;
            state   <= QUERY;
          end
        end

        QUERY: begin
          // Coordinates stay put while waiting; request falls right after the ack.
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (!occ_busy) begin
              // Commit outputs become visible during the COMMIT cycle itself.
              i_apple     <= occ_i;
              j_apple     <= occ_j;
              apple_valid <= 1'b1;
              spawn_done  <= 1'b1;
              state       <= COMMIT;
            end else begin
`ifdef APPLE_SCAN_FALLBACK_EN
              // A saturated try counter means this query came from the raster scan.
              if (try_cnt == TRY_MAX) begin
                if (scan_idx == 8'hFF) begin
                  board_full  <= 1'b1;
                  apple_valid <= 1'b0;
                  state       <= FULL;
                end else begin
                  scan_idx <= scan_idx + 8'd1;
                  state    <= SCAN;
                end
              end else begin
`else
              begin
`endif
                // Saturating, so unbounded retries never wrap the counter.
                if (try_cnt != TRY_MAX) begin
                  try_cnt <= try_cnt + 1'b1;
                end
                state <= GEN;
              end
            end
          end
        end

        COMMIT: begin
          try_cnt <= '0;
`ifdef APPLE_SCAN_FALLBACK_EN
          scan_idx <= '0;
`endif
          state   <= IDLE;
        end

`ifdef APPLE_SCAN_FALLBACK_EN
        SCAN: begin
          occ_i   <= scan_idx[7:4];
          occ_j   <= scan_idx[3:0];
          occ_req <= 1'b1;
          state   <= QUERY;
        end

        FULL: begin
          board_full  <= 1'b1;
          apple_valid <= 1'b0;
        end
`endif

        default: state <= IDLE;
      endcase

      // Abort overrides whatever the case statement scheduled this cycle.
      if (abort) begin
        state       <= IDLE;
        occ_req     <= 1'b0;
        apple_valid <= 1'b0;
        spawn_done  <= 1'b0;
        try_cnt     <= '0;
        locked      <= 1'b1;
`ifdef APPLE_SCAN_FALLBACK_EN
        scan_idx    <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: a transaction-level reference model
// (delay counters, integer scan index, arithmetic LFSR) is compared against the
// DUT every cycle, plus literal expectations for reset, first candidate and
// the directed corner cases. Fallback tests compile only with
// APPLE_SCAN_FALLBACK_EN defined.
module tb_apple_spawner;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          MAX_TRIES = 8;
`ifdef APPLE_SCAN_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  localparam int P_FREE   = 0;
  localparam int P_BUSY_N = 1;
  localparam int P_RANDOM = 2;
  localparam int P_EXCEPT = 3;
  localparam int P_ALL    = 4;
  localparam int P_NEVER  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameOver;
  logic       eaten;
  logic       occ_req;
  logic [3:0] occ_i, occ_j;
  logic       occ_ack, occ_busy;
  logic [3:0] i_apple, j_apple;
  logic       apple_valid, spawn_done, board_full;

  int total = 0;
  int bad   = 0;
  int n_spawn = 0;
  int req_count = 0;
  int req_base = 0;
  int busy_n = 0;
  int policy = P_FREE;
  int ack_wait = 0;

  apple_spawner #(
    .SEED      (SEED),
    .INIT_I    (4'd10),
    .INIT_J    (4'd14),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gameOver    (gameOver),
    .eaten       (eaten),
    .occ_req     (occ_req),
    .occ_i       (occ_i),
    .occ_j       (occ_j),
    .occ_ack     (occ_ack),
    .occ_busy    (occ_busy),
    .i_apple     (i_apple),
    .j_apple     (j_apple),
    .apple_valid (apple_valid),
    .spawn_done  (spawn_done),
    .board_full  (board_full)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  logic        m_req, m_av, m_done, m_full;
  logic [3:0]  m_qi, m_qj, m_ai, m_aj;
  logic        m_active, m_commit, m_locked;
  int          m_delay, m_tries, m_scan;

  always @(posedge clk or negedge reset) begin : model
    logic       req, av, done, full, active, commit, locked;
    logic [3:0] qi, qj, ai, aj;
    int         delay, tries, scan;
    if (!reset) begin
      m_lfsr <= SEED;   m_req <= 1'b0;  m_qi <= 4'd0;  m_qj <= 4'd0;
      m_ai <= 4'd10;    m_aj <= 4'd14;  m_av <= 1'b1;  m_done <= 1'b0;
      m_full <= 1'b0;   m_active <= 1'b0; m_commit <= 1'b0; m_locked <= 1'b0;
      m_delay <= 0;     m_tries <= 0;   m_scan <= -1;
    end else begin
      req = m_req; qi = m_qi; qj = m_qj; ai = m_ai; aj = m_aj; av = m_av;
      full = m_full; active = m_active; commit = m_commit; locked = m_locked;
      delay = m_delay; tries = m_tries; scan = m_scan; done = 1'b0;
      if (m_full) begin
        // board exhausted: everything frozen until reset
      end else if (m_active && gameOver) begin
        active = 1'b0; req = 1'b0; av = 1'b0; locked = 1'b1;
        commit = 1'b0; delay = 0; tries = 0; scan = -1;
      end else if (!m_active) begin
        if (eaten && !gameOver && !m_locked) begin
          active = 1'b1; av = 1'b0; delay = 1;
        end
      end else if (m_commit) begin
        commit = 1'b0; active = 1'b0; tries = 0; scan = -1;
      end else if (m_req) begin
        if (occ_ack) begin
          req = 1'b0;
          if (!occ_busy) begin
            ai = qi; aj = qj; av = 1'b1; done = 1'b1; commit = 1'b1;
          end else if (scan >= 0) begin
            if (scan == 255) full = 1'b1;
            else begin scan = scan + 1; delay = 1; end
          end else begin
            tries = tries + 1; delay = 1;
          end
        end
      end else if (delay > 0) begin
        delay = delay - 1;
        if (delay == 0) begin
          if (scan >= 0) begin
            qi = 4'(scan / 16); qj = 4'(scan % 16); req = 1'b1;
          end else if (FB && tries >= MAX_TRIES) begin
            scan = 0; delay = 1;
          end else begin
            qi = 4'(m_lfsr % 16); qj = 4'((m_lfsr / 16) % 16); req = 1'b1;
          end
        end
      end
      m_req <= req; m_qi <= qi; m_qj <= qj; m_ai <= ai; m_aj <= aj; m_av <= av;
      m_done <= done; m_full <= full; m_active <= active; m_commit <= commit;
      m_locked <= locked; m_delay <= delay; m_tries <= tries; m_scan <= scan;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // ---------------- occupancy tracker (stimulus) ----------------
  function automatic logic decide_busy();
    case (policy)
      P_BUSY_N: return (req_count - req_base) <= busy_n;
      P_RANDOM: return $urandom_range(0, 2) == 0;
      P_EXCEPT: return !(occ_i == 4'd3 && occ_j == 4'd7);
      P_ALL:    return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  initial begin : tracker
    logic in_req;
    int   wait_left;
    in_req = 1'b0; wait_left = 0;
    occ_ack = 1'b0; occ_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset || !occ_req) begin
        occ_ack = 1'b0; occ_busy = 1'b0; in_req = 1'b0;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          req_count = req_count + 1;
          wait_left = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
        end
        if (policy == P_NEVER || wait_left > 0) begin
          if (wait_left > 0) wait_left = wait_left - 1;
          occ_ack = 1'b0; occ_busy = 1'($urandom_range(0, 1));
        end else begin
          occ_ack = 1'b1; occ_busy = decide_busy();
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("occ_req", occ_req, m_req);
    if (m_req) begin
      check("occ_i", occ_i, m_qi);
      check("occ_j", occ_j, m_qj);
    end
    check("i_apple", i_apple, m_ai);
    check("j_apple", j_apple, m_aj);
    check("apple_valid", apple_valid, m_av);
    check("spawn_done", spawn_done, m_done);
    check("board_full", board_full, m_full);
    if (spawn_done) n_spawn = n_spawn + 1;
  endtask

  // One cycle: compare on the falling edge, return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; eaten = 1'b0; gameOver = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic pulse_eaten();
    eaten = 1'b1; step(); eaten = 1'b0;
  endtask

  task automatic wait_spawn(input int limit, input string name);
    int k = 0;
    while (!spawn_done && k < limit) begin step(); k++; end
    check(name, spawn_done, 1);
  endtask

  task automatic wait_req(input int limit, input string name);
    int k = 0;
    while (!occ_req && k < limit) begin step(); k++; end
    check(name, occ_req, 1);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    reset = 1'b0; eaten = 1'b0; gameOver = 1'b0;

    // 1: reset values
    policy = P_FREE; ack_wait = 1;
    do_reset();
    check("rst_i_apple", i_apple, 10);
    check("rst_j_apple", j_apple, 14);
    check("rst_apple_valid", apple_valid, 1);
    check("rst_occ_req", occ_req, 0);
    check("rst_spawn_done", spawn_done, 0);
    check("rst_board_full", board_full, 0);

    // 2: first spawn; GEN sees LFSR 16'hB387 -> candidate (7,8); ack after 1 wait
    step();
    pulse_eaten();
    check("gen_apple_valid_low", apple_valid, 0);
    step();
    check("q_req", occ_req, 1);
    check("q_i", occ_i, 7);
    check("q_j", occ_j, 8);
    step();
    check("q_req_held", occ_req, 1);
    check("q_i_held", occ_i, 7);
    check("q_j_held", occ_j, 8);
    step();
    check("commit_done", spawn_done, 1);
    check("commit_i", i_apple, 7);
    check("commit_j", j_apple, 8);
    check("commit_valid", apple_valid, 1);
    step();
    check("after_done", spawn_done, 0);
    check("after_req", occ_req, 0);

    // 3: three busy answers then free -> exactly four requests
    repeat (3) step();
    req_base = req_count; busy_n = 3; policy = P_BUSY_N; ack_wait = -1;
    pulse_eaten();
    wait_spawn(200, "busy3_spawn");
    check("busy3_req_count", req_count - req_base, 4);
    repeat (3) step();

    // 4: gameOver while the query is pending and unanswered
    policy = P_NEVER;
    pulse_eaten();
    wait_req(20, "go_req_seen");
    step(); step();
    s0 = n_spawn;
    gameOver = 1'b1;
    step();
    gameOver = 1'b0;
    check("go_req_drop", occ_req, 0);
    check("go_valid", apple_valid, 0);
    pulse_eaten();
    repeat (10) step();
    check("go_no_spawn", n_spawn - s0, 0);
    check("go_valid_stays", apple_valid, 0);

    // randomized traffic against the model, ending with reset mid-query
    do_reset();
    policy = P_RANDOM; ack_wait = -1;
    s0 = n_spawn;
    for (int c = 0; c < 1500; c++) begin
      eaten = ($urandom_range(0, 7) == 0);
      step();
    end
    eaten = 1'b0;
    check("random_spawned", int'(n_spawn > s0), 1);
    repeat (300) begin
      if (!occ_req) step();
    end
    if (!occ_req) begin
      repeat (5) step();
      pulse_eaten();
      wait_req(30, "midq_req_seen");
    end
    policy = P_NEVER;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_query_req", occ_req, 0);
    do_reset();

`ifdef APPLE_SCAN_FALLBACK_EN
    // 5: only (3,7) is free -> random tries, raster scan, commit (3,7)
    policy = P_EXCEPT; ack_wait = 0;
    step();
    pulse_eaten();
    wait_spawn(3000, "scan_spawn");
    check("scan_i", i_apple, 3);
    check("scan_j", j_apple, 7);
    check("scan_not_full", board_full, 0);
    step();

    // 6: every cell busy -> 8 random + 256 scan queries, then FULL
    do_reset();
    policy = P_ALL; ack_wait = 0;
    req_base = req_count;
    step();
    pulse_eaten();
    begin
      int k = 0;
      while (!board_full && k < 4000) begin step(); k++; end
    end
    check("full_flag", board_full, 1);
    check("full_valid", apple_valid, 0);
    check("full_req_count", req_count - req_base, MAX_TRIES + 256);
    pulse_eaten();
    repeat (10) step();
    check("full_sticky", board_full, 1);
    check("full_no_req", occ_req, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
